snes_poll_sched: RTL and testbench
==================================

# snes_poll_sched

Scheduler and bus controller for the two SNES controller ports in the I/O subsystem. It paces polling to the video frame: one poll per `frame_start` pulse. It drives the shared `con_latch`/`con_clock` lines and samples two serial data pins (player 1 and player 2) in the same pass. It publishes active-high 16-bit button snapshots plus pressed-edge masks to downstream consumers (CPU-visible registers, scroll logic), with a one-cycle valid strobe.

## Interface
Parameters:
- `LATCH_CYC`, default 600: cycles `con_latch` is held high (12 µs at 50 MHz); must be ≥ 2.
- `HALF_CYC`, default 300: cycles per half-period of `con_clock` (6 µs at 50 MHz); must be ≥ 4.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse marking the start of vblank.
- `poll_en`  in  1  level; frame_start is acted on only while high.
- `ovr_clr`  in  1  one-cycle pulse; clears `overrun`.
- `con_serial_p1`  in  1  player 1 data pin; asynchronous; low means pressed.
- `con_serial_p2`  in  1  player 2 data pin; asynchronous; low means pressed.
- `con_latch`  out  1  shared latch line.
- `con_clock`  out  1  shared clock line; idles high.
- `p1_state`  out  16  player 1 buttons; 1 means pressed.
- `p2_state`  out  16  player 2 buttons; 1 means pressed.
- `p1_pressed`  out  16  player 1 buttons that went 0→1 since the previous snapshot.
- `p2_pressed`  out  16  player 2 buttons that went 0→1 since the previous snapshot.
- `state_valid`  out  1  one-cycle strobe; all four vectors updated this cycle.
- `busy`  out  1  high while a poll is in progress.
- `overrun`  out  1  sticky; a frame_start arrived while busy.

## Operation
- Both serial inputs pass through a 2-flop synchronizer before sampling.
- FSM states are IDLE, LATCH, CLK_LO, CLK_HI, DONE. A down-counter `phase_cnt` times each phase and a 4-bit `bit_idx` tracks the bit position.
- IDLE: `con_latch`=0, `con_clock`=1, `busy`=0.
  - `frame_start && poll_en` loads `LATCH_CYC` and moves to LATCH.
  - `frame_start` with `poll_en`=0 is ignored; `overrun` is unaffected.
- LATCH: `con_latch`=1 for `LATCH_CYC` cycles, then CLK_LO with `bit_idx`=0.
- CLK_LO: `con_clock`=0 for `HALF_CYC` cycles.
  - On the last cycle, store the inverted synchronized data into shadow bit `bit_idx` for both players. Sampling mid-bit keeps the read clear of the controller's shift, which happens on the rising edge.
  - Then go to CLK_HI.
- CLK_HI: `con_clock`=1 for `HALF_CYC` cycles.
  - On the last cycle: if `bit_idx`==15, go to DONE; otherwise increment `bit_idx` and return to CLK_LO.
- DONE, one cycle:
  - `pN_pressed` ← `shadowN & ~pN_state` (uses the old state).
  - `pN_state` ← `shadowN`.
  - `state_valid`=1, `busy`=0. Return to IDLE.
- Bits 12–15 are reported as sampled. A genuine pad drives them high on the wire, so they read 0 after inversion. A disconnected pin pulled low reads 0xFFFF; flagging that is software's job.
- `frame_start` while `busy`: ignored, `overrun` set.
- `ovr_clr` together with a new overrun in the same cycle: set wins.
- `frame_start` in the DONE cycle counts as busy: overrun, not queued.
- `poll_en` dropping mid-poll does not abort; the current poll completes.
- Reset mid-poll: lines return immediately to idle levels and the partial shadow is discarded.

## Timing
- Reset values:
  - `con_latch`=0, `con_clock`=1.
  - All state, pressed and shadow vectors 0.
  - `state_valid`=0, `busy`=0, `overrun`=0.
  - FSM in IDLE.
- All outputs are registered.
- With `frame_start` sampled at edge t:
  - `busy` and `con_latch` go high at t+1.
  - `state_valid` is high for exactly one cycle at t+1+`LATCH_CYC`+32·`HALF_CYC`; `busy` is low that same cycle.
- Default parameters: poll latency 10201 cycles (≈204 µs), well inside vblank.
- Pressed masks hold their value until the next `state_valid`; they are not one-shot.
- Sample-path latency of 2 synchronizer cycles plus 1 register cycle requires `HALF_CYC` ≥ 4 for margin.

## Structure
- `ioss_pkg` holds:
  - `snes_btn_e` bit indices: B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11.
  - `snes_state_t` = `logic [15:0]`.
  - The FSM state enum.
- One sub-module, `sync2`, a 2-flop synchronizer instantiated per serial pin.
- The FSM and counters stay inline.

## Test plan
Bench parameters: `LATCH_CYC`=4, `HALF_CYC`=4; controller models shift on each `con_clock` rising edge.
- Reset, then idle 50 cycles → `con_clock`=1, `con_latch`=0, all outputs 0, no `state_valid`.
- P1 model 0xFEFF on the wire (A pressed), P2 0xFFFF; pulse `frame_start` at t → `state_valid` at t+133; `p1_state`=0x0100, `p1_pressed`=0x0100, `p2_state`=0x0000. Check 16 `con_clock` low pulses of 4 cycles each and a 4-cycle latch pulse.
- Repeat the poll with A still held and START added (wire 0xFEF7) → `p1_state`=0x0108, `p1_pressed`=0x0008.
- Second `frame_start` at t+50 → ignored, `overrun`=1, single `state_valid` at t+133. Then `ovr_clr` → `overrun`=0.
- `frame_start` with `poll_en`=0 → no latch pulse, `overrun` stays 0.
- Assert `reset` at t+60 mid-poll → next cycle `con_clock`=1, `con_latch`=0, `busy`=0, states 0. A fresh poll afterwards returns the correct value.

Source files
------------

// File: rtl/ioss_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ioss_pkg
//  Description : Shared types for the I/O subsystem controller-port logic.
//                Holds the SNES button bit indices, the 16-bit snapshot type
//                and the state encoding of the controller poll sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package ioss_pkg;

    // Bit position of each button inside a 16-bit snapshot, in the order the
    // pad shifts them out (bit 0 first). Bits 12..15 carry no button.
    typedef enum logic [3:0] {
        BTN_B      = 4'd0,
        BTN_Y      = 4'd1,
        BTN_SELECT = 4'd2,
        BTN_START  = 4'd3,
        BTN_UP     = 4'd4,
        BTN_DOWN   = 4'd5,
        BTN_LEFT   = 4'd6,
        BTN_RIGHT  = 4'd7,
        BTN_A      = 4'd8,
        BTN_X      = 4'd9,
        BTN_L      = 4'd10,
        BTN_R      = 4'd11
    } snes_btn_e;

    typedef logic [15:0] snes_state_t;

    // Poll sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } poll_state_e;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for one asynchronous input pin.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                d     - asynchronous input
//                q     - input resynchronized to clk (2-cycle latency)
//  Revision    : 1.0  initial release
// ============================================================================
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/snes_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module      : snes_poll_sched
//  Description : Frame-paced poll scheduler and bus controller for the two
//                SNES controller ports. One frame_start (with poll_en high)
//                runs one latch + 16-bit shift pass over the shared
//                con_latch/con_clock lines, sampling both pads together, and
//                publishes active-high snapshots and pressed-edge masks with
//                a one-cycle state_valid strobe.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                frame_start         - one-cycle poll request (start of vblank)
//                poll_en             - level gate for frame_start
//                ovr_clr             - one-cycle pulse clearing overrun
//                con_serial_p1/p2    - async pad data pins, low = pressed
//                con_latch/con_clock - shared pad control lines
//                p1/p2_state         - button snapshots, 1 = pressed
//                p1/p2_pressed       - buttons newly pressed since last snapshot
//                state_valid         - one-cycle strobe, vectors updated
//                busy                - poll in progress
//                overrun             - sticky, frame_start seen while busy
//  Revision    : 1.0  initial release
// ============================================================================
module snes_poll_sched
    import ioss_pkg::*;
#(
    parameter int LATCH_CYC = 600,
    parameter int HALF_CYC  = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        poll_en,
    input  logic        ovr_clr,
    input  logic        con_serial_p1,
    input  logic        con_serial_p2,
    output logic        con_latch,
    output logic        con_clock,
    output logic [15:0] p1_state,
    output logic [15:0] p2_state,
    output logic [15:0] p1_pressed,
    output logic [15:0] p2_pressed,
    output logic        state_valid,
    output logic        busy,
    output logic        overrun
);

    // The phase counter is loaded with (length - 1) and the phase ends on the
    // cycle it reads zero, so it only needs to hold the larger length - 1.
    localparam int CNT_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYC - 1);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic w_p1_sync;
    logic w_p2_sync;

    sync2 #(.RST_VAL(1'b1)) u_sync_p1 (
        .clk   (clk),
        .reset (reset),
        .d     (con_serial_p1),
        .q     (w_p1_sync)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_p2 (
        .clk   (clk),
        .reset (reset),
        .d     (con_serial_p2),
        .q     (w_p2_sync)
    );

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    poll_state_e      r_state;
    poll_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [CNT_W-1:0] w_phase_cnt_nxt;
    logic [3:0]       r_bit_idx;
    logic [3:0]       w_bit_idx_nxt;
    logic             w_phase_last;
    logic             w_sample;

    snes_state_t r_shadow_p1;
    snes_state_t r_shadow_p2;
    snes_state_t r_p1_state;
    snes_state_t r_p2_state;
    snes_state_t r_p1_pressed;
    snes_state_t r_p2_pressed;

    logic r_con_latch;
    logic r_con_clock;
    logic r_busy;
    logic r_state_valid;
    logic r_overrun;

    assign w_phase_last = (r_phase_cnt == '0);

    // Sample on the last low cycle: mid-bit, well away from the pad's shift
    // on the following rising edge of con_clock.
    assign w_sample = (r_state == ST_CLK_LO) && w_phase_last;

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_cnt_nxt = r_phase_cnt;
        w_bit_idx_nxt   = r_bit_idx;

        unique case (r_state)
            ST_IDLE: begin
                if (frame_start && poll_en) begin
                    w_state_nxt     = ST_LATCH;
                    w_phase_cnt_nxt = LATCH_LOAD;
                end
            end

            ST_LATCH: begin
                if (w_phase_last) begin
                    w_state_nxt     = ST_CLK_LO;
                    w_phase_cnt_nxt = HALF_LOAD;
                    w_bit_idx_nxt   = 4'd0;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt - 1'b1;
                end
            end

            ST_CLK_LO: begin
                if (w_phase_last) begin
                    w_state_nxt     = ST_CLK_HI;
                    w_phase_cnt_nxt = HALF_LOAD;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt - 1'b1;
                end
            end

            ST_CLK_HI: begin
                if (w_phase_last) begin
                    if (r_bit_idx == 4'd15) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt     = ST_CLK_LO;
                        w_phase_cnt_nxt = HALF_LOAD;
                        w_bit_idx_nxt   = r_bit_idx + 4'd1;
                    end
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt - 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state value so each line changes
    // together with the state it belongs to, with no decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_phase_cnt   <= '0;
            r_bit_idx     <= '0;
            r_con_latch   <= 1'b0;
            r_con_clock   <= 1'b1;
            r_busy        <= 1'b0;
            r_state_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_shadow_p1   <= '0;
            r_shadow_p2   <= '0;
            r_p1_state    <= '0;
            r_p2_state    <= '0;
            r_p1_pressed  <= '0;
            r_p2_pressed  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase_cnt   <= w_phase_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_con_latch   <= (w_state_nxt == ST_LATCH);
            r_con_clock   <= (w_state_nxt != ST_CLK_LO);
            r_busy        <= (w_state_nxt == ST_LATCH)  ||
                             (w_state_nxt == ST_CLK_LO) ||
                             (w_state_nxt == ST_CLK_HI);
            r_state_valid <= (w_state_nxt == ST_DONE);

            // Pad data is active-low on the wire.
            if (w_sample) begin
                r_shadow_p1[r_bit_idx] <= ~w_p1_sync;
                r_shadow_p2[r_bit_idx] <= ~w_p2_sync;
            end

            // Publish in the DONE cycle; pressed compares against the
            // snapshot being replaced.
            if (w_state_nxt == ST_DONE) begin
                r_p1_pressed <= r_shadow_p1 & ~r_p1_state;
                r_p2_pressed <= r_shadow_p2 & ~r_p2_state;
                r_p1_state   <= r_shadow_p1;
                r_p2_state   <= r_shadow_p2;
            end

            // A request while not idle (DONE included) is an overrun; a new
            // overrun beats a simultaneous clear.
            if (frame_start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign con_latch   = r_con_latch;
    assign con_clock   = r_con_clock;
    assign busy        = r_busy;
    assign state_valid = r_state_valid;
    assign overrun     = r_overrun;
    assign p1_state    = r_p1_state;
    assign p2_state    = r_p2_state;
    assign p1_pressed  = r_p1_pressed;
    assign p2_pressed  = r_p2_pressed;

endmodule
`default_nettype wire

// File: tb/tb_snes_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snes_poll_sched
//  Description : Self-checking bench for snes_poll_sched with two shift-
//                register pad models, a table of hand-derived polls, a few
//                corner-case sequences and randomized polls checked against
//                a snapshot/edge reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_snes_poll_sched;

    localparam int LATCH_CYC = 4;
    localparam int HALF_CYC  = 4;
    localparam int POLL_LAT  = 1 + LATCH_CYC + 32 * HALF_CYC;   // 133
    localparam int RUN_CYC   = POLL_LAT + 17;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        poll_en;
    logic        ovr_clr;
    logic        con_serial_p1;
    logic        con_serial_p2;
    logic        con_latch;
    logic        con_clock;
    logic [15:0] p1_state;
    logic [15:0] p2_state;
    logic [15:0] p1_pressed;
    logic [15:0] p2_pressed;
    logic        state_valid;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snes_poll_sched #(
        .LATCH_CYC (LATCH_CYC),
        .HALF_CYC  (HALF_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .poll_en       (poll_en),
        .ovr_clr       (ovr_clr),
        .con_serial_p1 (con_serial_p1),
        .con_serial_p2 (con_serial_p2),
        .con_latch     (con_latch),
        .con_clock     (con_clock),
        .p1_state      (p1_state),
        .p2_state      (p2_state),
        .p1_pressed    (p1_pressed),
        .p2_pressed    (p2_pressed),
        .state_valid   (state_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    // ------------------------------------------------------------------
    // Pad models: parallel load while latch is high, shift one bit on each
    // rising edge of con_clock, bit 0 on the data pin first.
    // ------------------------------------------------------------------
    logic [15:0] pad_w1 = 16'hFFFF;
    logic [15:0] pad_w2 = 16'hFFFF;
    logic [15:0] pad_sr1 = 16'hFFFF;
    logic [15:0] pad_sr2 = 16'hFFFF;
    logic        pad_prev_clk = 1'b1;

    always @(posedge clk) begin
        if (con_latch) begin
            pad_sr1 <= pad_w1;
            pad_sr2 <= pad_w2;
        end else if (con_clock && !pad_prev_clk) begin
            pad_sr1 <= {1'b1, pad_sr1[15:1]};
            pad_sr2 <= {1'b1, pad_sr2[15:1]};
        end
        pad_prev_clk <= con_clock;
    end

    assign con_serial_p1 = pad_sr1[0];
    assign con_serial_p2 = pad_sr2[0];

    // ------------------------------------------------------------------
    // Reference model: last published snapshots.
    // ------------------------------------------------------------------
    logic [15:0] m_prev1 = 16'h0000;
    logic [15:0] m_prev2 = 16'h0000;

    typedef struct {
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] e1s;
        logic [15:0] e1p;
        logic [15:0] e2s;
        logic [15:0] e2p;
        int          fs2_at;
        int          clr_at;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete poll. Cycle k is the k-th cycle after the edge that
    // samples frame_start; extra requests/clears/poll_en drop land on the
    // cycle numbers given (0 disables).
    task automatic do_poll(input string tag,
                           input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] e1s, input logic [15:0] e1p,
                           input logic [15:0] e2s, input logic [15:0] e2p,
                           input int fs2_at, input int clr_at, input int pen_drop_at,
                           input logic exp_ovr);
        int lat = -1;
        int nvalid = 0;
        int latch_cyc = 0;
        int busy_cyc = 0;
        int low_pulses = 0;
        int bad_low = 0;
        int cur_low = 0;
        logic prev_clk = 1'b1;
        logic busy_at1 = 1'b0;
        logic latch_at1 = 1'b0;
        logic busy_at_valid = 1'b1;
        logic [15:0] v1s = '0, v1p = '0, v2s = '0, v2p = '0;

        pad_w1      = w1;
        pad_w2      = w2;
        poll_en     = 1'b1;
        frame_start = 1'b1;
        for (int k = 1; k <= RUN_CYC; k++) begin
            tick();
            if (k == 1) begin
                busy_at1  = busy;
                latch_at1 = con_latch;
            end
            if (con_latch) latch_cyc++;
            if (busy) busy_cyc++;
            if (!con_clock) cur_low++;
            if (con_clock && !prev_clk) begin
                low_pulses++;
                if (cur_low != HALF_CYC) bad_low++;
                cur_low = 0;
            end
            prev_clk = con_clock;
            if (state_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = k;
                    busy_at_valid = busy;
                    v1s = p1_state;
                    v1p = p1_pressed;
                    v2s = p2_state;
                    v2p = p2_pressed;
                end
            end
            frame_start = (k + 1 == fs2_at);
            ovr_clr     = (k + 1 == clr_at);
            if (k + 1 == pen_drop_at) poll_en = 1'b0;
        end
        frame_start = 1'b0;
        ovr_clr     = 1'b0;
        poll_en     = 1'b1;

        chk({tag, ".latency"},     lat, POLL_LAT);
        chk({tag, ".nvalid"},      nvalid, 1);
        chk({tag, ".p1_state"},    v1s, e1s);
        chk({tag, ".p1_pressed"},  v1p, e1p);
        chk({tag, ".p2_state"},    v2s, e2s);
        chk({tag, ".p2_pressed"},  v2p, e2p);
        chk({tag, ".busy_start"},  {busy_at1, latch_at1}, 2'b11);
        chk({tag, ".busy_valid"},  busy_at_valid, 1'b0);
        chk({tag, ".busy_cyc"},    busy_cyc, POLL_LAT - 1);
        chk({tag, ".latch_cyc"},   latch_cyc, LATCH_CYC);
        chk({tag, ".clk_pulses"},  low_pulses, 16);
        chk({tag, ".clk_badlen"},  bad_low, 0);
        chk({tag, ".hold_p1p"},    p1_pressed, e1p);
        chk({tag, ".hold_p2p"},    p2_pressed, e2p);
        chk({tag, ".overrun"},     overrun, exp_ovr);
    endtask

    initial begin
        logic [15:0] rw1, rw2, e1s, e2s;
        int bad;
        int cnt;

        //            w1        w2        e1s       e1p       e2s       e2p     fs2 clr ovr
        vecs[0] = '{16'hFEFF, 16'hFFFF, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 0,  0, 1'b0};
        vecs[1] = '{16'hFEF7, 16'hFFFF, 16'h0108, 16'h0008, 16'h0000, 16'h0000, 0,  0, 1'b0};
        vecs[2] = '{16'hFEF7, 16'hFFFF, 16'h0108, 16'h0000, 16'h0000, 16'h0000, 50, 50, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 0,  10, 1'b0};
        vecs[4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0,  0, 1'b0};
        vecs[5] = '{16'h5555, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h5555, 16'h5555, 0,  0, 1'b0};

        reset       = 1'b1;
        frame_start = 1'b0;
        poll_en     = 1'b1;
        ovr_clr     = 1'b0;
        repeat (3) tick();
        chk("reset.lines", {con_latch, con_clock, busy, state_valid, overrun}, 5'b01000);
        chk("reset.vectors", {p1_state, p2_state} | {p1_pressed, p2_pressed}, 32'h0);
        reset = 1'b0;

        bad = 0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!con_clock || con_latch || busy || overrun) bad++;
            if (state_valid) cnt++;
        end
        chk("idle.lines", bad, 0);
        chk("idle.valid", cnt, 0);
        chk("idle.vectors", {p1_state, p2_state} | {p1_pressed, p2_pressed}, 32'h0);

        for (int v = 0; v < 6; v++) begin
            do_poll($sformatf("vec%0d", v), vecs[v].w1, vecs[v].w2,
                    vecs[v].e1s, vecs[v].e1p, vecs[v].e2s, vecs[v].e2p,
                    vecs[v].fs2_at, vecs[v].clr_at, 0, vecs[v].exp_ovr);
            m_prev1 = ~vecs[v].w1;
            m_prev2 = ~vecs[v].w2;
        end

        // frame_start with poll_en low: no activity at all.
        poll_en     = 1'b0;
        frame_start = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            frame_start = 1'b0;
            if (con_latch || busy || !con_clock || state_valid) bad++;
        end
        chk("pen0.activity", bad, 0);
        chk("pen0.overrun", overrun, 1'b0);
        poll_en = 1'b1;

        // Randomized polls, some with poll_en dropped mid-poll.
        for (int r = 0; r < 20; r++) begin
            rw1 = 16'($urandom);
            rw2 = 16'($urandom);
            e1s = ~rw1;
            e2s = ~rw2;
            do_poll($sformatf("rnd%0d", r), rw1, rw2,
                    e1s, e1s & ~m_prev1, e2s, e2s & ~m_prev2,
                    0, 0, (r % 2 == 1) ? int'($urandom_range(2, 130)) : 0, 1'b0);
            m_prev1 = e1s;
            m_prev2 = e2s;
        end

        // Reset in the middle of a poll.
        pad_w1      = 16'h0F0F;
        pad_w2      = 16'h3333;
        frame_start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            frame_start = 1'b0;
            if (k == 59) reset = 1'b1;
        end
        chk("rst.lines", {con_latch, con_clock, busy, state_valid}, 4'b0100);
        chk("rst.states", {p1_state, p2_state}, 32'h0);
        chk("rst.pressed", {p1_pressed, p2_pressed}, 32'h0);
        reset = 1'b0;
        tick();
        m_prev1 = 16'h0000;
        m_prev2 = 16'h0000;
        do_poll("postrst", 16'hFDFE, 16'hFFBF, 16'h0201, 16'h0201, 16'h0040, 16'h0040,
                0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
